list_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one list datapath instance among NUM_REQ requesters.
- Latches one requester's command and pulses op_en to the list for exactly one cycle.
- Tracks op_done/op_in_progress until the operation retires, forwards every result beat to the winner, then enforces the list's recovery cycle before the next issue.
- Sits between client engines and the list. The top level ties the list's active-high rst to ~rst_n.

---
 rtl/list_pkg.sv | 12 +
 rtl/list_arbiter_rr_picker.sv | 32 +++
 rtl/list_arbiter.sv | 117 +++++++++++
 tb/tb_list_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/list_pkg.sv
// list_pkg: list opcode encodings and arbiter state type shared by list_arbiter files
package list_pkg;
  localparam logic [2:0] OP_READ     = 3'b000;
  localparam logic [2:0] OP_INSERT   = 3'b001;
  localparam logic [2:0] OP_FIND_ALL = 3'b010;
  localparam logic [2:0] OP_FIND_1ST = 3'b011;
  localparam logic [2:0] OP_SUM      = 3'b100;
  localparam logic [2:0] OP_SORT_ASC = 3'b101;
  localparam logic [2:0] OP_SORT_DES = 3'b110;
  localparam logic [2:0] OP_DELETE   = 3'b111;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} arb_state_t;
endpackage

// File: rtl/list_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first set request at or after ptr
module rr_picker
  import list_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index
);
  logic [IW:0]   sum;
  logic [IW-1:0] j;
  // scan offsets from farthest to nearest so the nearest set request wins
  always_comb begin
    onehot = '0;
    index  = '0;
    sum    = '0;
    j      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IW + 1)'(i);
      sum = (sum >= (IW + 1)'(N)) ? sum - (IW + 1)'(N) : sum;
      j   = sum[IW-1:0];
      if (req[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        index     = j;
      end
    end
  end
endmodule

// File: rtl/list_arbiter.sv
// list_arbiter: round-robin sequencer sharing one list datapath; LIST_ARB_TIMEOUT_EN adds a WAIT watchdog
module list_arbiter
  import list_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int DATA_WIDTH     = 32,
  parameter  int LENGTH         = 8,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int LW             = $clog2(LENGTH),
  localparam int IW             = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*3-1:0]       req_op_sel,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*LW-1:0]      req_index,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       rsp_valid,
  output logic                       rsp_last,
  output logic                       rsp_error,
  output logic [LW+DATA_WIDTH-1:0]   rsp_data,
  output logic [IW-1:0]              rsp_id,
  output logic                       list_op_en,
  output logic [2:0]                 list_op_sel,
  output logic [DATA_WIDTH-1:0]      list_data_in,
  output logic [LW-1:0]              list_index_in,
  input  logic [LW+DATA_WIDTH-1:0]   list_data_out,
  input  logic                       list_op_done,
  input  logic                       list_op_in_progress,
  input  logic                       list_op_error
);
  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("list_arbiter: unsupported parameter set");
  end
  arb_state_t        state;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]     pick_index;
  logic [IW-1:0]     rr_ptr;
  logic              busy_q;
  logic              fall;
  logic              beat;
  logic              expire;
  assign fall = busy_q && !list_op_in_progress && !list_op_done;
  assign beat = list_op_done || fall;
  rr_picker #(.N(NUM_REQ)) u_picker (
    .req   (req),
    .ptr   (rr_ptr),
    .onehot(pick_onehot),
    .index (pick_index)
  );
`ifdef LIST_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd;
  assign expire = wd == TW'(TIMEOUT_CYCLES - 1);
  // count WAIT cycles since the last beat; anything else restarts the count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wd <= '0;
    else wd <= (state == WAIT && !beat) ? wd + 1'b1 : '0;
`else
  assign expire = 1'b0;
`endif
  // sequencer: grant, strobe the list once, forward beats, then rotate and recover
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      gnt           <= '0;
      rr_ptr        <= '0;
      busy_q        <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_last      <= 1'b0;
      rsp_error     <= 1'b0;
      rsp_data      <= '0;
      rsp_id        <= '0;
      list_op_en    <= 1'b0;
      list_op_sel   <= '0;
      list_data_in  <= '0;
      list_index_in <= '0;
    end else begin
      rsp_valid  <= 1'b0;
      rsp_last   <= 1'b0;
      list_op_en <= 1'b0;
      busy_q     <= list_op_in_progress;
      case (state)
        IDLE: if (|req) begin
          gnt           <= pick_onehot;
          rsp_id        <= pick_index;
          list_op_sel   <= req_op_sel[pick_index*3 +: 3];
          list_data_in  <= req_data[pick_index*DATA_WIDTH +: DATA_WIDTH];
          list_index_in <= req_index[pick_index*LW +: LW];
          list_op_en    <= 1'b1;
          state         <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (beat) begin
          rsp_valid <= 1'b1;
          rsp_last  <= !(list_op_done && list_op_in_progress);
          rsp_error <= list_op_done && list_op_error;
          rsp_data  <= list_data_out;
          state     <= (list_op_done && list_op_in_progress) ? WAIT : RESP;
        end else if (expire) begin
          rsp_valid <= 1'b1;
          rsp_last  <= 1'b1;
          rsp_error <= 1'b1;
          rsp_data  <= '1;
          state     <= RESP;
        end
        RESP: begin
          gnt    <= '0;
          rr_ptr <= (rsp_id == IW'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
          state  <= GAP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_list_arbiter.sv
// tb_list_arbiter: scoreboard bench for list_arbiter with a behavioural list stub
module tb_list_arbiter;
  import list_pkg::*;
  localparam int NR = 4, DW = 32, LEN = 8, LW = 3, IW = 2, TO = 16, RW = LW + DW;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR*3-1:0]  req_op_sel = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR*LW-1:0] req_index = '0;
  logic [NR-1:0]    gnt;
  logic             rsp_valid, rsp_last, rsp_error;
  logic [RW-1:0]    rsp_data;
  logic [IW-1:0]    rsp_id;
  logic             list_op_en;
  logic [2:0]       list_op_sel;
  logic [DW-1:0]    list_data_in;
  logic [LW-1:0]    list_index_in;
  logic [RW-1:0]    list_data_out;
  logic             list_op_done, list_op_in_progress, list_op_error;

  list_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LENGTH(LEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op_sel(req_op_sel), .req_data(req_data),
    .req_index(req_index), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_last(rsp_last),
    .rsp_error(rsp_error), .rsp_data(rsp_data), .rsp_id(rsp_id), .list_op_en(list_op_en),
    .list_op_sel(list_op_sel), .list_data_in(list_data_in), .list_index_in(list_index_in),
    .list_data_out(list_data_out), .list_op_done(list_op_done),
    .list_op_in_progress(list_op_in_progress), .list_op_error(list_op_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [RW-1:0] data;
    logic          err;
    logic          last;
    logic [DW-1:0] din;
    logic [NR-1:0] g;
  } beat_t;
  typedef struct packed {logic done, ip, err; logic [RW-1:0] d;} step_t;

  beat_t exp_q[$], obs_q[$];
  int total = 0, bad = 0;

  // list stub: each command becomes a cycle-by-cycle plan of list outputs
  step_t plan[$];
  logic [DW-1:0] mem[LEN];
  int cnt = 0;
  bit hang = 0, load_sa = 0;

  task automatic stub_start();
    int ix = int'(list_index_in);
    logic [RW-1:0] sum = '0;
    int hits[$];
    if (hang) begin
      repeat (60) plan.push_back({3'b010, RW'(0)});
      return;
    end
    plan.push_back({3'b010, RW'(0)});
    case (list_op_sel)
      OP_INSERT: begin
        for (int k = LEN - 1; k > ix; k--) mem[k] = mem[k-1];
        mem[ix] = list_data_in;
        if (cnt < LEN) cnt++;
        plan.push_back({3'b100, RW'(0)});
      end
      OP_READ: plan.push_back(ix < cnt ? {3'b100, RW'(mem[ix])} : {3'b101, RW'(0)});
      OP_FIND_ALL: begin
        for (int k = 0; k < cnt; k++) if (mem[k] == list_data_in) hits.push_back(k);
        foreach (hits[k]) plan.push_back({1'b1, k != hits.size() - 1, 1'b0, RW'(hits[k])});
        if (hits.size() == 0) plan.push_back({3'b100, RW'(0)});
      end
      OP_SUM: begin
        for (int k = 0; k < cnt; k++) sum += RW'(mem[k]);
        repeat (2) plan.push_back({3'b010, RW'(0)});
        plan.push_back({3'b001, sum});
      end
      OP_SORT_ASC: begin
        repeat (100) plan.push_back({3'b010, RW'(0)});
        plan.push_back({3'b100, RW'(0)});
      end
      default: plan.push_back({3'b100, RW'(0)});
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plan.delete();
      cnt = 0;
      {list_op_done, list_op_in_progress, list_op_error, list_data_out} <= '0;
    end else begin
      if (load_sa) begin
        mem[0] = 5; mem[1] = 7; mem[2] = 5; mem[3] = 5;
        cnt = 4;
      end
      if (list_op_en) stub_start();
      if (plan.size() > 0) {list_op_done, list_op_in_progress, list_op_error, list_data_out} <= plan.pop_front();
      else {list_op_done, list_op_in_progress, list_op_error} <= '0;
    end
  end

  always @(negedge clk) if (rsp_valid) obs_q.push_back({rsp_id, rsp_data, rsp_error, rsp_last, list_data_in, gnt});

  function automatic beat_t mk(int id, logic [RW-1:0] d, logic e, logic l, logic [DW-1:0] din);
    return '{IW'(id), d, e, l, din, NR'(1) << id};
  endfunction

  task automatic set_cmd(int id, logic [2:0] op, logic [DW-1:0] d, logic [LW-1:0] ix);
    req_op_sel[id*3 +: 3] = op;
    req_data[id*DW +: DW] = d;
    req_index[id*LW +: LW] = ix;
  endtask

  task automatic wait_beats(int n);
    for (int c = 0; c < 400 && obs_q.size() < n; c++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_op_en();
    for (int c = 0; c < 20 && !list_op_en; c++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #12;
    total++; if (gnt !== '0) begin bad++; $display("FAIL reset_gnt got=%b want=0", gnt); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (list_op_en !== 1'b0) begin bad++; $display("FAIL reset_op_en got=%b want=0", list_op_en); end
    total++; if ({list_op_sel, list_data_in, list_index_in} !== '0) begin bad++; $display("FAIL reset_cmd got=%h want=0", {list_op_sel, list_data_in, list_index_in}); end
    total++; if ({rsp_data, rsp_error, rsp_last, rsp_id} !== '0) begin bad++; $display("FAIL reset_rsp got=%h want=0", {rsp_data, rsp_error, rsp_last, rsp_id}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (gnt !== '0) begin bad++; $display("FAIL idle_gnt got=%b want=0", gnt); end
  endtask

  task automatic test_insert();
    exp_q.push_back(mk(0, 0, 0, 1, 32'h11));
    exp_q.push_back(mk(0, 0, 0, 1, 32'h22));
    set_cmd(0, OP_INSERT, 32'h11, 0); req = 4'b0001;
    wait_beats(1);
    set_cmd(0, OP_INSERT, 32'h22, 1);
    wait_beats(2); req = '0;
    for (int i = 0; i < 2; i++) begin
      beat_t o, e;
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      total++; if (o !== e) begin bad++; $display("FAIL insert beat%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_single_read();
    exp_q.push_back(mk(2, 32'h22, 0, 1, 0));
    set_cmd(2, OP_READ, 0, 1); req = 4'b0100;
    wait_op_en();
    total++; if ({list_op_en, gnt, list_op_sel, list_index_in} !== {1'b1, 4'b0100, OP_READ, 3'd1})
      begin bad++; $display("FAIL read_issue got=%b want=%b", {list_op_en, gnt, list_op_sel, list_index_in}, {1'b1, 4'b0100, OP_READ, 3'd1}); end
    @(negedge clk); #1;
    total++; if (list_op_en !== 1'b0) begin bad++; $display("FAIL op_en_pulse got=%b want=0", list_op_en); end
    wait_beats(1); req = '0;
    begin
      beat_t o, e;
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      total++; if (o !== e) begin bad++; $display("FAIL single_read got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_error();
    exp_q.push_back(mk(3, 0, 1, 1, 0));
    set_cmd(3, OP_READ, 0, 6); req = 4'b1000;
    wait_beats(1); req = '0;
    begin
      beat_t o, e;
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      total++; if (o !== e) begin bad++; $display("FAIL error_pass got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_contention();
    for (int i = 0; i < NR; i++) set_cmd(i, OP_READ, 0, 0);
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(mk(0, 32'h11, 0, 1, 0));
    exp_q.push_back(mk(1, 32'h11, 0, 1, 0));
    exp_q.push_back(mk(3, 32'h11, 0, 1, 0));
    exp_q.push_back(mk(0, 32'h11, 0, 1, 0));
    req = 4'b1011;
    wait_beats(3); req = 4'b1111;
    wait_beats(4); req = '0;
    for (int i = 0; i < 4; i++) begin
      beat_t o, e;
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      total++; if (o !== e) begin bad++; $display("FAIL contention txn%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_search_all();
    load_sa = 1; @(negedge clk); load_sa = 0;
    exp_q.push_back(mk(1, 0, 0, 0, 5));
    exp_q.push_back(mk(1, 2, 0, 0, 5));
    exp_q.push_back(mk(1, 3, 0, 1, 5));
    set_cmd(1, OP_FIND_ALL, 5, 0); req = 4'b0010;
    wait_beats(3); req = '0;
    for (int i = 0; i < 3; i++) begin
      beat_t o, e;
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      total++; if (o !== e) begin bad++; $display("FAIL search_all beat%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_sum();
    exp_q.push_back(mk(2, 22, 0, 1, 0));
    set_cmd(2, OP_SUM, 0, 0); req = 4'b0100;
    wait_beats(1); req = '0;
    begin
      beat_t o, e;
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      total++; if (o !== e) begin bad++; $display("FAIL sum_fall got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_async_reset();
    set_cmd(0, OP_SORT_ASC, 0, 0); req = 4'b0001;
    wait_op_en();
    repeat (4) @(negedge clk);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL sort_gnt got=%b want=0001", gnt); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({gnt, rsp_valid, list_op_en} !== '0) begin bad++; $display("FAIL async_reset got=%b want=0", {gnt, rsp_valid, list_op_en}); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL reset_no_beat got=%0d want=0", obs_q.size()); end
    req = 4'b0110;
    set_cmd(1, OP_READ, 0, 0); set_cmd(2, OP_READ, 0, 0);
    exp_q.push_back(mk(1, 0, 1, 1, 0));
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    wait_beats(1); req = '0;
    begin
      beat_t o, e;
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      total++; if (o !== e) begin bad++; $display("FAIL post_reset got=%h want=%h", o, e); end
    end
  endtask

`ifdef LIST_ARB_TIMEOUT_EN
  task automatic test_timeout();
    repeat (3) @(negedge clk);
    hang = 1;
    exp_q.push_back(mk(2, '1, 1, 1, 0));
    set_cmd(2, OP_READ, 0, 0); req = 4'b0100;
    wait_beats(1); req = '0;
    begin
      beat_t o, e;
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front(); else o = 'x;
      total++; if (o !== e) begin bad++; $display("FAIL timeout got=%h want=%h", o, e); end
    end
    repeat (4) @(negedge clk);
    total++; if ({gnt, list_op_en} !== '0) begin bad++; $display("FAIL timeout_idle got=%b want=0", {gnt, list_op_en}); end
    hang = 0;
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_insert();
    test_single_read();
    test_error();
    test_contention();
    test_search_all();
    test_sum();
    test_async_reset();
`ifdef LIST_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (10) @(negedge clk);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL stray_beats got=%0d want=0", obs_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
